cam_sccb_init: RTL

//  Camera register initialiser. Sits upstream of the camera capture path.

---
 rtl/cam_sccb_init.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cam_sccb_init.sv
// cam_sccb_init: after power-up walks a {reg,value} ROM and writes each pair to the camera over SCCB.
// Build option SCCB_DELAY_EN: entry 16'hFFF0 becomes a 10*PWR_WAIT idle delay instead of a write.
module cam_sccb_init #(
  parameter int         CLK_DIV  = 125,
  parameter int         PWR_WAIT = 50000,
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter int         ROM_AW   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sio_c,
  output logic              o_sio_d_out,
  output logic              o_sio_d_oe,
  output logic              o_busy,
  output logic              o_cam_cfg_done,
  output logic [7:0]        o_wr_count
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int WW = $clog2(10 * PWR_WAIT + 1);
  localparam logic [2:0] S_PWR = 3'd0, S_FETCH = 3'd1, S_STRT = 3'd2, S_BITS = 3'd3,
                         S_STOP = 3'd4, S_GAP = 3'd5, S_DONE = 3'd6;
`ifdef SCCB_DELAY_EN
  localparam logic [2:0] S_DELAY = 3'd7;
`endif
  logic [2:0]        r_state;
  logic [DW-1:0]     r_div;
  logic [WW-1:0]     r_wait;
  logic [1:0]        r_tick;
  logic [4:0]        r_bit;
  logic              r_fetch_hi;
  logic [7:0]        r_reg, r_val, r_cnt;
  logic [ROM_AW-1:0] r_addr;
  logic              r_sio_c, r_sio_d, r_sio_oe;
  logic              w_bus, w_tick, w_last, w_ack, w_end, w_c, w_d, w_oe;
  logic [1:0]        w_last_tick;
  logic [26:0]       w_frame;
  assign w_bus       = r_state inside {S_STRT, S_BITS, S_STOP, S_GAP};
  assign w_tick      = w_bus && (r_div == DW'(CLK_DIV - 1));
  assign w_last_tick = (r_state == S_STRT) ? 2'd1 : (r_state == S_STOP) ? 2'd2 : 2'd3;
  assign w_last      = w_tick && (r_tick == w_last_tick);
  assign w_end       = &r_addr;
  // ack slots carry 1 so the released line matches the pulled-up value
  assign w_frame     = {DEV_ID, 1'b1, r_reg, 1'b1, r_val, 1'b1};
  assign w_ack       = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
  always_comb begin
    w_c  = (r_state == S_STRT) ? (r_tick == 2'd0) :
           (r_state == S_BITS) ? r_tick[1] :
           (r_state == S_STOP) ? (r_tick != 2'd0) : 1'b1;
    w_d  = (r_state == S_STRT) ? 1'b0 :
           (r_state == S_BITS) ? w_frame[5'd26 - r_bit] :
           (r_state == S_STOP) ? (r_tick == 2'd2) : 1'b1;
    w_oe = (r_state == S_STRT) || (r_state == S_STOP) || ((r_state == S_BITS) && !w_ack);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state    <= S_PWR;
      r_div      <= '0;
      r_wait     <= '0;
      r_tick     <= '0;
      r_bit      <= '0;
      r_fetch_hi <= 1'b0;
      r_reg      <= '0;
      r_val      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_sio_c    <= 1'b1;
      r_sio_d    <= 1'b1;
      r_sio_oe   <= 1'b0;
    end else begin
      r_div    <= (w_bus && !w_tick) ? r_div + 1'b1 : '0;
      r_sio_c  <= w_c;
      r_sio_d  <= w_d;
      r_sio_oe <= w_oe;
      if (w_tick) r_tick <= w_last ? 2'd0 : r_tick + 2'd1;
      case (r_state)
        S_PWR: begin
          r_wait <= r_wait + 1'b1;
          if (r_wait == WW'(PWR_WAIT - 1)) begin
            r_wait  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_fetch_hi <= !r_fetch_hi;
          if (r_fetch_hi) begin
            {r_reg, r_val} <= i_rom_data;
            r_state <= (i_rom_data == 16'hFFFF) ? S_DONE : S_STRT;
`ifdef SCCB_DELAY_EN
            if (i_rom_data == 16'hFFF0) r_state <= S_DELAY;
`endif
          end
        end
        S_STRT: if (w_last) r_state <= S_BITS;
        S_BITS: if (w_last) begin
          r_bit <= (r_bit == 5'd26) ? 5'd0 : r_bit + 5'd1;
          if (r_bit == 5'd26) r_state <= S_STOP;
        end
        S_STOP: if (w_last) r_state <= S_GAP;
        S_GAP: if (w_last) begin
          r_cnt   <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
          r_addr  <= w_end ? r_addr : r_addr + 1'b1;
          r_state <= w_end ? S_DONE : S_FETCH;
        end
`ifdef SCCB_DELAY_EN
        S_DELAY: begin
          r_wait <= r_wait + 1'b1;
          if (r_wait == WW'(10 * PWR_WAIT - 1)) begin
            r_wait  <= '0;
            r_addr  <= w_end ? r_addr : r_addr + 1'b1;
            r_state <= w_end ? S_DONE : S_FETCH;
          end
        end
`endif
        default: if (i_start) begin
          r_cnt   <= '0;
          r_addr  <= '0;
          r_state <= S_FETCH;
        end
      endcase
    end
  assign o_rom_addr     = r_addr;
  assign o_sio_c        = r_sio_c;
  assign o_sio_d_out    = r_sio_d;
  assign o_sio_d_oe     = r_sio_oe;
  assign o_busy         = !((r_state == S_PWR) || (r_state == S_DONE));
  assign o_cam_cfg_done = (r_state == S_DONE);
  assign o_wr_count     = r_cnt;
endmodule
